dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/proc_pkg.sv | 15 +
 rtl/dmem_arbiter_if.sv | 43 ++++
 rtl/age_counter.sv | 25 ++
 rtl/dmem_arbiter.sv | 90 +++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: bus width and the read-return ownership tag
// used by the data-memory arbiter and its starvation counter.
package proc_pkg;

  localparam int DATA_W = 18;
  localparam int AGE_W  = 4;

  // Which requester owns the read data returning from the RAM this cycle.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    VID  = 2'd2
  } rd_owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU MEM-stage port, the video fetch port and the RAM port.
// slave: the arbiter's view. master: the environment (CPU, video, RAM).
interface dmem_arbiter_if;
  import proc_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              vid_req;
  logic [DATA_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  vid_req, vid_addr,
    output vid_gnt, vid_rvalid, vid_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output vid_req, vid_addr,
    input  vid_gnt, vid_rvalid, vid_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/age_counter.sv
// Saturating starvation counter: counts cycles a requester is denied,
// stops at sat, and clears when the requester is served or goes idle.
module age_counter
  import proc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic [AGE_W-1:0] sat,
  output logic [AGE_W-1:0] count
);

  // Count register: clear wins over increment, increment stops at sat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != sat)) begin
      count <= count + AGE_W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port synchronous RAM between the
// CPU MEM stage and a read-only video fetcher. The CPU normally wins; the
// video requester takes priority once it has been denied AGE_MAX cycles.
module dmem_arbiter
  import proc_pkg::*;
#(
  parameter int AGE_MAX = 4
)
(
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_MAX);

  rd_owner_t         rd_owner;
  rd_owner_t         rd_owner_nxt;
  logic              cpu_ok;
  logic              vid_ok;
  logic              vid_pri;
  logic              grant_cpu;
  logic              grant_vid;
  logic              age_inc;
  logic              age_clr;
  logic [AGE_W-1:0]  age;
  logic [DATA_W-1:0] cpu_rdata_q;

  // Starvation age of the video requester.
  assign age_inc = bus.vid_req & ~grant_vid;
  assign age_clr = grant_vid | ~bus.vid_req;

  age_counter u_age (
    .clk   (clk),
    .rst   (rst),
    .inc   (age_inc),
    .clr   (age_clr),
    .sat   (AGE_SAT),
    .count (age)
  );

  // Grant selection and next read owner; grants are forced off while in reset.
  always_comb begin
    cpu_ok       = bus.cpu_req & (rd_owner != CPU);
    vid_ok       = bus.vid_req;
    vid_pri      = vid_ok & (age == AGE_SAT);
    grant_cpu    = rst & cpu_ok & ~vid_pri;
    grant_vid    = rst & vid_ok & ~grant_cpu;
    rd_owner_nxt = NONE;
    if (grant_cpu && !bus.cpu_we) begin
      rd_owner_nxt = CPU;
    end else if (grant_vid) begin
      rd_owner_nxt = VID;
    end
  end

  // RAM port, requester handshakes and read-data steering.
  always_comb begin
    bus.mem_en     = grant_cpu | grant_vid;
    bus.mem_we     = grant_cpu & bus.cpu_we;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    if (grant_cpu) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (grant_vid) begin
      bus.mem_addr  = bus.vid_addr;
    end
    bus.vid_gnt    = grant_vid;
    bus.vid_rvalid = (rd_owner == VID);
    bus.vid_rdata  = (rd_owner == VID) ? bus.mem_rdata : '0;
    // Returning CPU data is forwarded in the cycle the stall drops.
    bus.cpu_rdata  = (rd_owner == CPU) ? bus.mem_rdata : cpu_rdata_q;
    bus.cpu_stall  = rst & bus.cpu_req & ~(grant_cpu & bus.cpu_we) & (rd_owner != CPU);
  end

  // Read-return ownership and captured CPU read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_owner    <= NONE;
      cpu_rdata_q <= '0;
    end else begin
      rd_owner <= rd_owner_nxt;
      if (rd_owner == CPU) begin
        cpu_rdata_q <= bus.mem_rdata;
      end
    end
  end

endmodule
